// File: rtl/axi_m_line.sv
// axi_m_line: AXI4 master that turns one line request into an INCR burst (memory) or one FIXED beat (device).
// Defining AXI_M_LINE_RLAST_CHK_EN enables RLAST checking; an early RLAST then also ends the read.
module axi_m_line #(
    parameter int WIDTH_ID = 1,
    parameter int WIDTH_AD = 32,
    parameter int WIDTH_DA = 32,
    parameter int LINE_W   = 128,
    parameter int DEV_BIT  = 29
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rw_i,
    input  logic [WIDTH_AD-1:0]   req_addr_i,
    input  logic [LINE_W-1:0]     req_wdata_i,
    input  logic [WIDTH_DA/8-1:0] req_strb_i,
    output logic [LINE_W-1:0]     rsp_rdata_o,
    output logic                  rd_done_o,
    output logic                  wr_done_o,
    output logic                  rsp_err_o,
    output logic [WIDTH_ID-1:0]   M_AXI_AWID,
    output logic [WIDTH_AD-1:0]   M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWLOCK,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic [3:0]            M_AXI_AWQOS,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [WIDTH_DA-1:0]   M_AXI_WDATA,
    output logic [WIDTH_DA/8-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [WIDTH_ID-1:0]   M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [WIDTH_ID-1:0]   M_AXI_ARID,
    output logic [WIDTH_AD-1:0]   M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARLOCK,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic [2:0]            M_AXI_ARPROT,
    output logic [3:0]            M_AXI_ARQOS,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [WIDTH_ID-1:0]   M_AXI_RID,
    input  logic [WIDTH_DA-1:0]   M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int         NBEAT   = LINE_W / WIDTH_DA;
    localparam int         CW      = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [7:0] MEM_LEN = 8'(NBEAT - 1);
    localparam logic [2:0] SIZE    = 3'($clog2(WIDTH_DA / 8));

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t                state, state_next;
    logic [WIDTH_AD-1:0]   addr_q;
    logic [LINE_W-1:0]     line_q;
    logic [LINE_W-1:0]     line_merge;
    logic [WIDTH_DA/8-1:0] strb_q;
    logic                  dev_q;
    logic                  err_q;
    logic [CW-1:0]         cnt;
    logic [7:0]            len;
    logic                  beat_last;
    logic                  r_err;
    logic                  r_end;
    logic                  unused_ok;

    assign len       = dev_q ? 8'd0 : MEM_LEN;
    assign beat_last = (8'(cnt) == len);

`ifdef AXI_M_LINE_RLAST_CHK_EN
    assign r_err     = M_AXI_RRESP[1] | (M_AXI_RLAST != beat_last);
    assign r_end     = beat_last | M_AXI_RLAST;
    assign unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_BRESP[0], M_AXI_RRESP[0]};
`else
    assign r_err     = M_AXI_RRESP[1];
    assign r_end     = beat_last;
    assign unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_BRESP[0], M_AXI_RRESP[0], M_AXI_RLAST};
`endif

    assign req_ready_o   = (state == S_IDLE);

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len;
    assign M_AXI_AWSIZE  = SIZE;
    assign M_AXI_AWBURST = dev_q ? 2'b00 : 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = dev_q ? 4'b0000 : 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_WDATA   = line_q[cnt*WIDTH_DA +: WIDTH_DA];
    assign M_AXI_WSTRB   = dev_q ? strb_q : '1;
    assign M_AXI_WLAST   = beat_last;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len;
    assign M_AXI_ARSIZE  = SIZE;
    assign M_AXI_ARBURST = dev_q ? 2'b00 : 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = dev_q ? 4'b0000 : 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;

    // Reads assemble into the capture register so rsp_rdata_o only changes when a read completes.
    always_comb begin
        line_merge = line_q;
        if (dev_q) begin
            line_merge                 = '0;
            line_merge[WIDTH_DA-1:0]   = M_AXI_RDATA;
        end else begin
            line_merge[cnt*WIDTH_DA +: WIDTH_DA] = M_AXI_RDATA;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) state <= S_IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next    = state;
        M_AXI_ARVALID = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            S_IDLE: if (req_valid_i) state_next = req_rw_i ? S_AR : S_AW;
            S_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_next = S_R;
            end
            S_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && r_end) state_next = S_IDLE;
            end
            S_AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_next = S_W;
            end
            S_W: begin
                M_AXI_WVALID = 1'b1;
                if (M_AXI_WREADY && beat_last) state_next = S_B;
            end
            S_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            addr_q      <= '0;
            line_q      <= '0;
            strb_q      <= '0;
            dev_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt         <= '0;
            rsp_rdata_o <= '0;
            rd_done_o   <= 1'b0;
            wr_done_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            rd_done_o <= 1'b0;
            wr_done_o <= 1'b0;
            case (state)
                S_IDLE: if (req_valid_i) begin
                    addr_q    <= req_addr_i;
                    line_q    <= req_rw_i ? '0 : req_wdata_i;
                    strb_q    <= req_strb_i;
                    dev_q     <= req_addr_i[DEV_BIT];
                    err_q     <= 1'b0;
                    rsp_err_o <= 1'b0;
                    cnt       <= '0;
                end
                S_R: if (M_AXI_RVALID) begin
                    if (r_end) begin
                        rsp_rdata_o <= line_merge;
                        rd_done_o   <= 1'b1;
                        rsp_err_o   <= err_q | r_err;
                        cnt         <= '0;
                    end else begin
                        line_q <= line_merge;
                        err_q  <= err_q | r_err;
                        cnt    <= cnt + CW'(1);
                    end
                end
                S_W: if (M_AXI_WREADY) cnt <= beat_last ? '0 : cnt + CW'(1);
                S_B: if (M_AXI_BVALID) begin
                    wr_done_o <= 1'b1;
                    rsp_err_o <= err_q | M_AXI_BRESP[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_m_line.sv
// tb_axi_m_line: directed vector table plus hand sequences for axi_m_line with a reactive AXI slave.
// Expectations for the early-RLAST vector depend on AXI_M_LINE_RLAST_CHK_EN.
module tb_axi_m_line;

    localparam int WIDTH_ID = 1;
    localparam int WIDTH_AD = 32;
    localparam int WIDTH_DA = 32;
    localparam int LINE_W   = 128;
    localparam int DEV_BIT  = 29;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_rw;
    logic [31:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [3:0]    req_strb;
    logic [127:0]  rsp_rdata;
    logic          rd_done, wr_done, rsp_err;
    logic [0:0]    awid, arid, bid, rid;
    logic [31:0]   awaddr, araddr, wdata, rdata;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awlock, arlock;
    logic [3:0]    awcache, arcache, awqos, arqos, wstrb;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;

    axi_m_line #(.WIDTH_ID(WIDTH_ID), .WIDTH_AD(WIDTH_AD), .WIDTH_DA(WIDTH_DA),
                 .LINE_W(LINE_W), .DEV_BIT(DEV_BIT)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_rdata_o(rsp_rdata), .rd_done_o(rd_done), .wr_done_o(wr_done), .rsp_err_o(rsp_err),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
        .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] wline;
        logic [3:0]   strb;
        logic [127:0] rline;
        int           err_beat;
        int           rlast_beat;
        logic         bresp_err;
        logic         wtoggle;
        logic [7:0]   exp_len;
        logic [1:0]   exp_burst;
        logic [127:0] exp_rdata;
        logic [3:0]   exp_strb;
        int           exp_beats;
        int           exp_lat;
        logic         exp_err;
    } vec_t;

    vec_t         vecs[9];
    int           n_compared   = 0;
    int           n_mismatched = 0;
    logic [127:0] last_rdata   = '0;

    function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [127:0] wline,
                                input logic [3:0] strb, input logic [127:0] rline, input int err_beat,
                                input int rlast_beat, input logic bresp_err, input logic wtoggle,
                                input logic [7:0] exp_len, input logic [1:0] exp_burst,
                                input logic [127:0] exp_rdata, input logic [3:0] exp_strb,
                                input int exp_beats, input int exp_lat, input logic exp_err);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wline = wline; v.strb = strb; v.rline = rline;
        v.err_beat = err_beat; v.rlast_beat = rlast_beat; v.bresp_err = bresp_err;
        v.wtoggle = wtoggle; v.exp_len = exp_len; v.exp_burst = exp_burst;
        v.exp_rdata = exp_rdata; v.exp_strb = exp_strb; v.exp_beats = exp_beats;
        v.exp_lat = exp_lat; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    endtask

    // Drives one request, plays a zero-wait (or WREADY-toggling) slave and checks every beat.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int   cyc, beat, wcyc;
        bit   done, seen_addr;
        @(negedge clk);
        req_valid = 1'b1; req_rw = v.rw; req_addr = v.addr; req_wdata = v.wline; req_strb = v.strb;
        check_output($sformatf("v%0d req_ready_idle", idx), req_ready, 1'b1);
        @(posedge clk);
        cyc = 0; beat = 0; wcyc = 0; done = 0; seen_addr = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = '1; req_strb = 4'hF;
            slave_idle();
            if (rd_done || wr_done) begin
                done = 1;
                check_output($sformatf("v%0d latency", idx), cyc, v.exp_lat);
                check_output($sformatf("v%0d beats", idx), beat, v.exp_beats);
                check_output($sformatf("v%0d rd_done_kind", idx), rd_done, v.rw);
                check_output($sformatf("v%0d wr_done_kind", idx), wr_done, !v.rw);
                check_output($sformatf("v%0d err", idx), rsp_err, v.exp_err);
                check_output($sformatf("v%0d ready_in_done", idx), req_ready, 1'b1);
                if (v.rw) last_rdata = v.exp_rdata;
                check_output($sformatf("v%0d rdata", idx), rsp_rdata, last_rdata);
            end else begin
                if (cyc == 1) check_output($sformatf("v%0d addr_valid_t1", idx), v.rw ? arvalid : awvalid, 1'b1);
                if ((arvalid || awvalid) && !seen_addr) begin
                    seen_addr = 1;
                    check_output($sformatf("v%0d addr", idx), v.rw ? araddr : awaddr, v.addr);
                    check_output($sformatf("v%0d len", idx), v.rw ? arlen : awlen, v.exp_len);
                    check_output($sformatf("v%0d burst", idx), v.rw ? arburst : awburst, v.exp_burst);
                    check_output($sformatf("v%0d size", idx), v.rw ? arsize : awsize, 3'd2);
                end
                arready = arvalid;
                awready = awvalid;
                if (rready) begin
                    rvalid = 1'b1;
                    rdata  = v.rline[beat*32 +: 32];
                    rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
                    rlast  = (beat == v.rlast_beat);
                    beat++;
                end
                if (wvalid) begin
                    wready = !v.wtoggle || (wcyc % 2 == 1);
                    wcyc++;
                    check_output($sformatf("v%0d wdata b%0d", idx, beat), wdata, v.wline[beat*32 +: 32]);
                    check_output($sformatf("v%0d wstrb b%0d", idx, beat), wstrb, v.exp_strb);
                    check_output($sformatf("v%0d wlast b%0d", idx, beat), wlast, beat == v.exp_beats - 1);
                    if (wready) beat++;
                end
                if (bready) begin
                    bvalid = 1'b1;
                    bresp  = v.bresp_err ? 2'b10 : 2'b00;
                end
            end
        end
        if (!done) check_output($sformatf("v%0d timeout", idx), 1'b0, 1'b1);
        @(negedge clk);
        check_output($sformatf("v%0d done_one_cycle", idx), rd_done | wr_done, 1'b0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        slave_idle();

        vecs[0] = mk(1, 32'h0000_1000, '0, 4'h0, 128'h00000044_00000033_00000022_00000011, -1, 3, 0, 0,
                     8'd3, 2'b01, 128'h00000044_00000033_00000022_00000011, 4'hF, 4, 6, 0);
        vecs[1] = mk(0, 32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4'h0, '0, -1, -1, 0, 1,
                     8'd3, 2'b01, '0, 4'hF, 4, 11, 0);
        vecs[2] = mk(0, 32'h2000_0004, 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_12345678, 4'h3, '0, -1, -1, 0, 0,
                     8'd0, 2'b00, '0, 4'h3, 1, 4, 0);
        vecs[3] = mk(1, 32'h0000_3000, '0, 4'h0, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 1, 3, 0, 0,
                     8'd3, 2'b01, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 4'hF, 4, 6, 1);
        vecs[4] = mk(1, 32'h0000_3040, '0, 4'h0, 128'h0BADBEEF_13579BDF_2468ACE0_FEDCBA98, -1, 3, 0, 0,
                     8'd3, 2'b01, 128'h0BADBEEF_13579BDF_2468ACE0_FEDCBA98, 4'hF, 4, 6, 0);
        vecs[5] = mk(1, 32'h2000_0010, '0, 4'h0, 128'h99999999_88888888_77777777_CAFEF00D, -1, 0, 0, 0,
                     8'd0, 2'b00, 128'h00000000_00000000_00000000_CAFEF00D, 4'hF, 1, 3, 0);
        vecs[6] = mk(0, 32'h0000_4000, 128'h44444444_33333333_22222222_11111111, 4'h0, '0, -1, -1, 1, 0,
                     8'd3, 2'b01, '0, 4'hF, 4, 7, 1);
        vecs[7] = mk(0, 32'h0000_4040, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 4'h0, '0, -1, -1, 0, 0,
                     8'd3, 2'b01, '0, 4'hF, 4, 7, 0);
`ifdef AXI_M_LINE_RLAST_CHK_EN
        vecs[8] = mk(1, 32'h0000_5000, '0, 4'h0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, -1, 1, 0, 0,
                     8'd3, 2'b01, 128'h00000000_00000000_D2D2D2D2_D1D1D1D1, 4'hF, 2, 4, 1);
`else
        vecs[8] = mk(1, 32'h0000_5000, '0, 4'h0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, -1, 1, 0, 0,
                     8'd3, 2'b01, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1, 4'hF, 4, 6, 0);
`endif

        @(negedge clk);
        @(negedge clk);
        check_output("reset req_ready", req_ready, 1'b1);
        check_output("reset valids", {arvalid, awvalid, wvalid}, 3'b000);
        check_output("reset readies", {rready, bready}, 2'b00);
        check_output("reset done", {rd_done, wr_done}, 2'b00);
        check_output("reset err", rsp_err, 1'b0);
        check_output("reset rdata", rsp_rdata, '0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

        // Reset in the middle of a write data phase with the slave stalling WREADY.
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0000_6000; req_wdata = '1; req_strb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!wvalid && cyc < 10) begin
            awready = awvalid;
            @(negedge clk);
            cyc++;
        end
        slave_idle();
        check_output("midrst wvalid_before", wvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_output("midrst wvalid_async", wvalid, 1'b0);
        check_output("midrst other_valids", {awvalid, arvalid, bready, rready}, 4'b0000);
        check_output("midrst req_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        last_rdata = '0;
        apply_stimulus(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/axi_m_line.md
# axi_m_line

Parametrised AXI4 master bridge between the core's cache/uncached request port and the system AXI interconnect. Converts one line-sized request into an INCR burst of `LINE_W/WIDTH_DA` beats for memory regions, or into a single-beat FIXED transfer with byte strobes for device regions. Unlike the fixed 128-bit/32-bit bridge, it uses AXI4 length encoding, drives ready only when a response is expected, and reports response errors.

## Interface
Parameters:
- `WIDTH_ID`, 1: AXI ID width; all IDs driven 0.
- `WIDTH_AD`, 32: address width.
- `WIDTH_DA`, 32: AXI data width; power of two, ≥ 8.
- `LINE_W`, 128: line width. `NBEAT = LINE_W/WIDTH_DA` must be a power of two, 1..256.
- `DEV_BIT`, 29: address bit that selects a device region (1 = device, single beat).

Ports:
- `M_AXI_ACLK` in 1: clock.
- `M_AXI_ARESET` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: high in IDLE only.
- `req_rw_i` in 1: 1 = read, 0 = write.
- `req_addr_i` in WIDTH_AD: byte address; line-aligned for memory region.
- `req_wdata_i` in LINE_W: write line; beat k = `[k*WIDTH_DA +: WIDTH_DA]`.
- `req_strb_i` in WIDTH_DA/8: byte strobes, device writes only.
- `rsp_rdata_o` out LINE_W: read line, stable until next read completes.
- `rd_done_o`, `wr_done_o` out 1: one-cycle completion pulses.
- `rsp_err_o` out 1: error flag, valid with done pulse.
- Complete AXI4 AW/W/B/AR/R channel set (`M_AXI_*`), AWLEN/ARLEN 8 bits, AWSIZE/ARSIZE 3, AWBURST/ARBURST 2.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE: on `req_valid_i & req_ready_o`, capture addr, wdata, strb, rw, region (`addr[DEV_BIT]`); go to AR (read) or AW (write).
- Memory region: LEN = NBEAT-1, BURST = INCR(01). Device region: LEN = 0, BURST = FIXED(00). SIZE = log2(WIDTH_DA/8).
- AR: ARVALID=1 held until ARREADY; then R.
- R: RREADY=1; beat counter `cnt` (log2 NBEAT bits, min 1) stores RDATA into lane `cnt`. Device read stores lane 0, clears all other lanes. On final beat (cnt==LEN): pulse `rd_done_o`, return IDLE, cnt=0.
- AW: AWVALID=1 until AWREADY; then W.
- W: WVALID=1, WDATA = lane `cnt` of captured line, WSTRB = all ones (memory) or captured strb (device), WLAST = (cnt==LEN). Advance on WREADY; after last beat go B.
- B: BREADY=1; on BVALID pulse `wr_done_o`, return IDLE.
- Error: any RRESP/BRESP with bit1 set during the transaction sets a sticky per-transaction flag, presented on `rsp_err_o` with the done pulse, cleared on next accept.

## Timing
- Reset: state IDLE, all AXI valids/readies 0, `req_ready_o` 1 (IDLE), done pulses 0, `rsp_err_o` 0, `rsp_rdata_o` 0, cnt 0.
- Accept at edge t → ARVALID/AWVALID high from t+1.
- Done pulse registered: high the cycle after final RVALID/BVALID handshake; `req_ready_o` high in that same cycle; back-to-back accept allowed.
- VALID never deasserts before handshake; payload stable while VALID high.
- Minimum latency with zero-wait slave: read 2+NBEAT cycles, write 3+NBEAT cycles accept-to-done.
- Request inputs ignored outside IDLE.
- Reset mid-transaction: immediate abandon, all outputs to reset values; interconnect is reset together.

## Configuration
- `AXI_M_LINE_RLAST_CHK_EN` defined: RLAST compared with (cnt==LEN) every read beat; mismatch sets the error flag; an early RLAST also ends the read (done pulse, IDLE). Undefined: RLAST ignored, read ends solely by beat count; error reflects RRESP/BRESP only.

## Test plan
- Read, memory, NBEAT=4, RDATA 0x11,0x22,0x33,0x44 zero-wait → ARLEN=3, ARBURST=01, `rsp_rdata_o`=0x00000044_00000033_00000022_00000011, `rd_done_o` pulse 6 cycles after accept, `rsp_err_o`=0.
- Write, memory, line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, WREADY toggling → WDATA AA..,BB..,CC..,DD.. in order, WSTRB=0xF, WLAST only on 4th beat, single `wr_done_o`.
- Device write addr 0x2000_0004, strb 0x3 → AWLEN=0, AWBURST=00, WSTRB=0x3, WLAST=1 on first beat.
- Read with RRESP=2'b10 on beat 2 → `rsp_err_o`=1 with `rd_done_o`; next clean read → `rsp_err_o`=0.
- With macro: RLAST asserted on beat 2 of 4 → done pulse after beat 2, err=1; without macro: RLAST ignored, done after beat 4.
- Reset asserted while in W state with WVALID=1 → WVALID falls without clock edge; after release, new read completes normally.
